// File: rtl/fir_dec_mac.sv
// Decimating FIR filter with runtime-loadable coefficients.
// A single time-multiplexed multiplier-accumulator computes one product per clock.
// Every DEC-th accepted sample starts a TAPS-cycle MAC pass. The result is
// arithmetically shifted, saturated to WOUT bits and presented with a one-cycle
// y_valid pulse. While a pass is running, samples and coefficient writes are refused.
`timescale 1ns/1ps
module fir_dec_mac #(
    parameter  int WIN   = 8,
    parameter  int WCOEF = 10,
    parameter  int TAPS  = 21,
    parameter  int DEC   = 5,
    parameter  int WOUT  = 20,
    parameter  int SHIFT = 0,
    localparam int WA    = $clog2(TAPS),
    localparam int WACC  = WIN + WCOEF + $clog2(TAPS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIN-1:0]   X,
    input  logic                    x_valid,
    output logic                    x_ready,
    input  logic                    coef_we,
    input  logic [WA-1:0]           coef_addr,
    input  logic signed [WCOEF-1:0] coef_data,
    output logic                    coef_ready,
    output logic signed [WOUT-1:0]  Y,
    output logic                    y_valid
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int WP    = (DEC > 1) ? $clog2(DEC) : 1;
    localparam int WPROD = WIN + WCOEF;
    // Saturation compares in a width that holds both the accumulator and the output range.
    localparam int WS    = ((WACC > WOUT) ? WACC : WOUT) + 1;

    localparam logic [WP-1:0]        PH_LAST  = WP'(DEC - 1);
    localparam logic [WA-1:0]        IDX_LAST = WA'(TAPS - 1);
    localparam logic signed [WS-1:0] SAT_MAX  = {{(WS - WOUT + 1){1'b0}}, {(WOUT - 1){1'b1}}};
    localparam logic signed [WS-1:0] SAT_MIN  = {{(WS - WOUT + 1){1'b1}}, {(WOUT - 1){1'b0}}};

    logic [1:0]               state_q, state_d;
    logic [WP-1:0]            phase_q, phase_d;
    logic [WA-1:0]            idx_q, idx_d;
    logic signed [WACC-1:0]   acc_q, acc_d;
    logic signed [WOUT-1:0]   y_q, y_d;
    logic                     y_valid_q, y_valid_d;
    logic signed [WIN-1:0]    d_q [TAPS];
    logic signed [WCOEF-1:0]  c_q [TAPS];

    logic                     accept;
    logic                     coef_wr;
    logic signed [WPROD-1:0]  d_ext, c_ext, prod;
    logic signed [WACC-1:0]   prod_ext, acc_sh;
    logic signed [WS-1:0]     acc_wide;
    logic signed [WOUT-1:0]   sat_val;

    assign x_ready    = (state_q == S_IDLE);
    assign coef_ready = x_ready;
    assign accept     = x_valid && x_ready;
    assign coef_wr    = coef_we && coef_ready;
    assign Y          = y_q;
    assign y_valid    = y_valid_q;

    // Product of the currently addressed tap, sign-extended to the accumulator width.
    assign d_ext    = {{WCOEF{d_q[idx_q][WIN-1]}}, d_q[idx_q]};
    assign c_ext    = {{WIN{c_q[idx_q][WCOEF-1]}}, c_q[idx_q]};
    assign prod     = d_ext * c_ext;
    assign prod_ext = {{(WACC - WPROD){prod[WPROD-1]}}, prod};
    assign acc_sh   = acc_q >>> SHIFT;
    assign acc_wide = {{(WS - WACC){acc_sh[WACC-1]}}, acc_sh};

    // Clamp the shifted accumulator into the signed output range.
    always_comb begin
        sat_val = acc_wide[WOUT-1:0];
        if (acc_wide > SAT_MAX) begin
            sat_val = SAT_MAX[WOUT-1:0];
        end else if (acc_wide < SAT_MIN) begin
            sat_val = SAT_MIN[WOUT-1:0];
        end
    end

    // Control FSM next state: decimation phase, tap counter, accumulator, output.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = S_MAC;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            S_MAC: begin
                acc_d = acc_q + prod_ext;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                y_d       = sat_val;
                y_valid_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers; reset aborts any pass in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    // One register per tap: delay line shifts on accept, coefficient loads on a matching write.
    // Out-of-range addresses match no tap and are therefore dropped.
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
        localparam logic [WA-1:0] TAP_ADDR = WA'(gi);

        // Delay line stage gi (stage 0 holds the newest sample).
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                d_q[gi] <= '0;
            end else if (accept) begin
                if (gi == 0) begin
                    d_q[gi] <= X;
                end else begin
                    d_q[gi] <= d_q[(gi == 0) ? 0 : gi - 1];
                end
            end
        end

        // Coefficient register for tap gi.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                c_q[gi] <= '0;
            end else if (coef_wr && (coef_addr == TAP_ADDR)) begin
                c_q[gi] <= coef_data;
            end
        end
    end

endmodule

// File: tb/tb_fir_dec_mac.sv
// Scoreboard bench for fir_dec_mac. Three instances (default, WOUT=12, SHIFT=8)
// share one stimulus stream; a fourth (DEC=1) runs a randomly gated stream
// against a convolution model. Expected results are queued at the triggering
// accept and popped by an independent monitor on every y_valid pulse.
`timescale 1ns/1ps
module tb_fir_dec_mac;

    localparam int TAPS = 21;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Shared stimulus for the DEC=5 instances.
    logic signed [7:0] X         = '0;
    logic              x_valid   = 1'b0;
    logic              coef_we   = 1'b0;
    logic [4:0]        coef_addr = '0;
    logic signed [9:0] coef_data = '0;

    logic xr_a, cr_a, yv_a, xr_s, cr_s, yv_s, xr_h, cr_h, yv_h;
    logic signed [19:0] Y_a, Y_h;
    logic signed [11:0] Y_s;

    // Stimulus for the DEC=1 instance.
    logic signed [7:0] dX    = '0;
    logic              dv    = 1'b0;
    logic              dwe   = 1'b0;
    logic [4:0]        daddr = '0;
    logic signed [9:0] ddata = '0;
    logic               xr_d, cr_d, yv_d;
    logic signed [19:0] Y_d;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle_cnt = 0;
    int lowcnt   = 0;
    int n_acc_d  = 0;
    int n_out_d  = 0;

    exp_t q_a[$];
    int   q_s[$];
    int   q_h[$];
    int   q_d[$];

    int m_c[TAPS];
    int m_d[TAPS];

    fir_dec_mac dut_a (
        .clk(clk), .reset(rst_n), .X(X), .x_valid(x_valid), .x_ready(xr_a),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_ready(cr_a), .Y(Y_a), .y_valid(yv_a)
    );
    fir_dec_mac #(.WOUT(12)) dut_s (
        .clk(clk), .reset(rst_n), .X(X), .x_valid(x_valid), .x_ready(xr_s),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_ready(cr_s), .Y(Y_s), .y_valid(yv_s)
    );
    fir_dec_mac #(.SHIFT(8)) dut_h (
        .clk(clk), .reset(rst_n), .X(X), .x_valid(x_valid), .x_ready(xr_h),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_ready(cr_h), .Y(Y_h), .y_valid(yv_h)
    );
    fir_dec_mac #(.DEC(1)) dut_d (
        .clk(clk), .reset(rst_n), .X(dX), .x_valid(dv), .x_ready(xr_d),
        .coef_we(dwe), .coef_addr(daddr), .coef_data(ddata),
        .coef_ready(cr_d), .Y(Y_d), .y_valid(yv_d)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic chk(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        int   ev;
        forever begin
            @(negedge clk);
            // x_ready must be low for exactly TAPS+1 cycles per output.
            if (!rst_n) begin
                lowcnt = 0;
            end else if (!xr_a) begin
                lowcnt++;
            end else if (lowcnt != 0) begin
                chk("x_ready_low_cycles", lowcnt, 22);
                lowcnt = 0;
            end
            if (rst_n) begin
                chk("ready_lockstep",
                    int'((cr_a == xr_a) && (xr_s == xr_a) && (cr_s == xr_a) &&
                         (xr_h == xr_a) && (cr_h == xr_a) && (cr_d == xr_d)), 1);
            end
            if (yv_a) begin
                if (q_a.size() == 0) begin
                    chk("Y_a_unexpected_pulse", 1, 0);
                end else begin
                    e = q_a.pop_front();
                    $display("OUT a Y=%0d expected=%0d", $signed(Y_a), e.val);
                    chk("Y_a", $signed(Y_a), e.val);
                    chk("latency_a", cycle_cnt - e.cyc, 22);
                end
            end
            if (yv_s) begin
                if (q_s.size() == 0) begin
                    chk("Y_s_unexpected_pulse", 1, 0);
                end else begin
                    ev = q_s.pop_front();
                    chk("Y_s_wout12", $signed(Y_s), ev);
                end
            end
            if (yv_h) begin
                if (q_h.size() == 0) begin
                    chk("Y_h_unexpected_pulse", 1, 0);
                end else begin
                    ev = q_h.pop_front();
                    chk("Y_h_shift8", $signed(Y_h), ev);
                end
            end
            if (yv_d) begin
                n_out_d++;
                if (q_d.size() == 0) begin
                    chk("Y_d_unexpected_pulse", 1, 0);
                end else begin
                    ev = q_d.pop_front();
                    $display("OUT d Y=%0d expected=%0d", $signed(Y_d), ev);
                    chk("Y_d_dec1", $signed(Y_d), ev);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push3(input int ea, input int es, input int eh);
        exp_t e;
        e.val = ea;
        e.cyc = cycle_cnt;
        q_a.push_back(e);
        q_s.push_back(es);
        q_h.push_back(eh);
    endtask

    task automatic send(input int x);
        int g;
        g = 0;
        X = x[7:0];
        x_valid = 1'b1;
        while (!xr_a && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) chk("send_ready_timeout", 0, 1);
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    task automatic wcoef(input int addr, input int data);
        int g;
        g = 0;
        coef_addr = addr[4:0];
        coef_data = data[9:0];
        coef_we   = 1'b1;
        while (!cr_a && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) chk("coef_ready_timeout", 0, 1);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Five accepts: first sample then four copies of rest. Optional coefficient
    // write coincides with the triggering (fifth) accept.
    task automatic group5(input int first, input int rest, input bit expect_out,
                          input int ea, input int es, input int eh,
                          input bit wr, input int wa, input int wd);
        send(first);
        for (int k = 0; k < 3; k++) send(rest);
        if (wr) begin
            coef_addr = wa[4:0];
            coef_data = wd[9:0];
            coef_we   = 1'b1;
        end
        send(rest);
        coef_we = 1'b0;
        if (expect_out) push3(ea, es, eh);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q_a.size() != 0 || q_s.size() != 0 || q_h.size() != 0 || q_d.size() != 0) && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("drain_pending_outputs", q_a.size() + q_s.size() + q_h.size() + q_d.size(), 0);
    endtask

    task automatic dwcoef(input int addr, input int data);
        daddr = addr[4:0];
        ddata = data[9:0];
        dwe   = 1'b1;
        while (!cr_d) @(negedge clk);
        @(negedge clk);
        dwe = 1'b0;
    endtask

    // DEC=1 send: junk is driven on X while refused, the real sample once ready.
    task automatic dsend(input int x);
        int g;
        int sum;
        g = 0;
        dv = 1'b1;
        while (!xr_d && g < 100) begin
            dX = 8'($urandom_range(0, 255));
            @(negedge clk);
            g++;
        end
        if (g >= 100) chk("dsend_ready_timeout", 0, 1);
        dX = x[7:0];
        @(negedge clk);
        dv = 1'b0;
        for (int i = TAPS - 1; i > 0; i--) m_d[i] = m_d[i-1];
        m_d[0] = x;
        sum = 0;
        for (int i = 0; i < TAPS; i++) sum += m_c[i] * m_d[i];
        if (sum > 524287) sum = 524287;
        if (sum < -524288) sum = -524288;
        q_d.push_back(sum);
        n_acc_d++;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int imp[6];
        int dc_a[5];
        int dc_s[5];
        int dc_h[5];
        int ng_a[5];
        int ng_s[5];
        int ng_h[5];
        int post[5];
        int t4[4];

        imp  = '{5, 10, 15, 20, 0, 0};
        dc_a = '{635, 1270, 1905, 2540, 2667};
        dc_s = '{635, 1270, 1905, 2047, 2047};
        dc_h = '{2, 4, 7, 9, 10};
        ng_a = '{524287, 59787, -524288, -524288, -524288};
        ng_s = '{2047, 2047, -2048, -2048, -2048};
        ng_h = '{2778, 233, -2312, -4857, -5366};
        post = '{10, 20, 30, 40, 0};
        t4   = '{45, 35, 20, 0};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("reset_Y", $signed(Y_a), 0);
        chk("reset_y_valid", int'(yv_a), 0);
        chk("reset_x_ready", int'(xr_a), 1);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Impulse response with c[i]=i+1.
        for (int i = 0; i < TAPS; i++) wcoef(i, i + 1);
        for (int k = 0; k < 6; k++)
            group5((k == 0) ? 1 : 0, 0, 1'b1, imp[k], imp[k], 0, 1'b0, 0, 0);
        drain();

        // DC with unit coefficients: fill-in then steady 21*127.
        for (int i = 0; i < TAPS; i++) wcoef(i, 1);
        for (int k = 0; k < 5; k++)
            group5(127, 127, 1'b1, dc_a[k], dc_s[k], dc_h[k], 1'b0, 0, 0);
        drain();

        // Saturation and shift with c=511.
        for (int i = 0; i < TAPS; i++) wcoef(i, 511);
        group5(127, 127, 1'b1, 524287, 2047, 5323, 1'b0, 0, 0);
        for (int k = 0; k < 5; k++)
            group5(-128, -128, 1'b1, ng_a[k], ng_s[k], ng_h[k], 1'b0, 0, 0);
        drain();

        // Reset 10 cycles into a MAC pass: no output from the aborted pass.
        group5(1, 0, 1'b0, 0, 0, 0, 1'b0, 0, 0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_Y", $signed(Y_a), 0);
        chk("abort_Y_s", $signed(Y_s), 0);
        chk("abort_Y_h", $signed(Y_h), 0);
        chk("abort_y_valid", int'(yv_a), 0);
        chk("abort_x_ready", int'(xr_a), 1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < TAPS; i++) wcoef(i, i + 1);
        for (int k = 0; k < 5; k++)
            group5((k == 0) ? 2 : 0, 0, 1'b1, post[k], post[k], 0, 1'b0, 0, 0);
        drain();

        // Coefficient gating.
        group5(1, 0, 1'b1, 9, 9, 0, 1'b1, 4, 9);   // same-edge write + trigger
        coef_addr = 5'd4;
        coef_data = 10'sd100;
        coef_we   = 1'b1;                           // refused: MAC in progress
        @(negedge clk);
        @(negedge clk);
        coef_we = 1'b0;
        group5(1, 0, 1'b1, 19, 19, 0, 1'b0, 0, 0);
        wcoef(4, -7);
        wcoef(25, 300);                             // out of range: dropped
        group5(1, 0, 1'b1, 18, 18, 0, 1'b0, 0, 0);
        for (int k = 0; k < 4; k++)
            group5(0, 0, 1'b1, t4[k], t4[k], 0, 1'b0, 0, 0);
        drain();

        // DEC=1 with random gating against a convolution model.
        for (int i = 0; i < TAPS; i++) begin
            m_c[i] = ((i * 73) % 301) - 150;
            m_d[i] = 0;
            dwcoef(i, m_c[i]);
        end
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            dsend(int'($urandom_range(0, 255)) - 128);
        end
        drain();
        repeat (3) @(negedge clk);
        chk("dec1_outputs_vs_accepts", n_out_d, n_acc_d);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #900000;
        $display("FAIL global_timeout time=%0t required=finish_before_limit", $time);
        $fatal(1, "time limit");
    end

endmodule
